mmio_bus_arbiter: RTL
=====================

// Module: mmio_bus_arbiter
// PURPOSE
//  Shares the single MMIO bus (bus_addr/bus_wr_data/bus_cs/bus_wr/bus_rd/bus_rd_data) between two requesters.
//  Requester 0 is the pipelined core's memory stage; requester 1 is the debug/DMA port.
//  Arbitration is round-robin. The arbiter registers each transaction onto the bus and waits for a peripheral ack.
//  A timeout counter bounds the wait. On completion it returns read data and a one-cycle done pulse to the owner.
// PARAMETERS
//  TIMEOUT_CYCLES  16   max ACTIVE cycles waiting for bus_ack before forced error completion (>=1)
//  ERR_DATA        32'hDEADBEEF  read data returned on timeout
// PORTS
//  clk          in   1   clock, rising edge
//  reset        in   1   reset, asynchronous, active-high
//  m0_req       in   1   core request; held high until m0_done cycle inclusive
//  m0_wr        in   1   1=write, 0=read; stable while m0_req high
//  m0_addr      in   32  byte address; stable while m0_req high
//  m0_wdata     in   32  write data; stable while m0_req high
//  m0_gnt       out  1   m0 owns the bus (ACTIVE or DONE with owner=0)
//  m0_done      out  1   one-cycle completion pulse
//  m0_err       out  1   valid with m0_done: 1 = timeout
//  m0_rdata     out  32  read data, valid with m0_done
//  m1_*         same set as m0_* for requester 1
//  bus_addr     out  32  registered address of current transaction
//  bus_wr_data  out  32  registered write data
//  bus_cs       out  1   high for every ACTIVE cycle
//  bus_wr       out  1   bus_cs & latched wr
//  bus_rd       out  1   bus_cs & ~latched wr
//  bus_rd_data  in   32  peripheral read data, sampled when bus_ack=1
//  bus_ack      in   1   peripheral completion; ignored outside ACTIVE
// BEHAVIOUR
//  Reset: state=IDLE, prio=0 (m0 favoured), owner=0, timer=0. All outputs are 0.
//   Asserting reset mid-transaction drops bus_cs on the same edge, with no done pulse.
//  FSM IDLE -> ACTIVE -> DONE -> IDLE.
//  IDLE:
//   - No req: stay.
//   - One req: grant it.
//   - Both req: grant m[prio].
//   - On grant, latch addr/wdata/wr/owner, clear timer, and go to ACTIVE. bus_cs rises the cycle after req is seen (1-cycle latency).
//  ACTIVE: bus_cs=1 and timer increments each cycle.
//   - bus_ack=1: latch bus_rd_data (write: latch 0), err=0, go to DONE.
//   - Otherwise, timer==TIMEOUT_CYCLES-1: latch ERR_DATA, err=1, go to DONE.
//   - ack and timeout in the same cycle: ack wins (err=0).
//  DONE: bus_cs=0; m[owner]_done=1 with rdata/err valid; prio <= ~owner; go to IDLE.
//  Requesters must drop req the cycle after done. A req still high in IDLE is a new transaction.
//  Non-owner done/err/rdata stay 0. rdata holds its value only in the done cycle (0 otherwise).
//  Back-to-back use: a transaction occupies the bus at least 3 cycles (IDLE, ACTIVE, DONE).
//   Two always-requesting masters alternate strictly.
//  Requests arriving during ACTIVE/DONE wait; there is no preemption and no request queue beyond req-level holding.
//  timer width = $clog2(TIMEOUT_CYCLES)+1 and never wraps; it is reset on each grant.
//  bus_addr/bus_wr_data hold the last transaction's values when idle; bus_cs gates their meaning.
// TESTING
//  1. m0 read 0x1000_0004, ack 2 cycles after bus_cs with bus_rd_data=0x55AA -> bus_rd=1 for 3 cycles, m0_done=1, m0_rdata=0x55AA, m0_err=0.
//  2. m0 and m1 req same cycle from reset -> m0 granted first. m1 granted in the IDLE after m0_done. Third simultaneous round grants m0.
//  3. m1 write 0x1000_0010 data 0x1234, never ack -> bus_wr=1 for exactly 16 cycles, m1_done=1, m1_err=1, m1_rdata=0xDEADBEEF.
//  4. bus_ack on the 16th ACTIVE cycle (timeout coincident) -> m0_err=0, rdata = bus_rd_data.
//  5. reset asserted during ACTIVE -> bus_cs/bus_wr/bus_rd=0 immediately, no done pulse. After release, a pending m1 req is served normally.
//  6. m0 holds req after done for one extra cycle -> treated as a second transaction with an identical bus cycle. Check that m1 waiting takes priority if it is also requesting.

Source files
------------

// File: rtl/mmio_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mmio_bus_arbiter_if
// Description : Signal bundle for the two-requester MMIO bus arbiter. Carries
//               both requester handshakes and the shared peripheral bus.
//               The master modport is the arbiter's view (it drives the bus);
//               the slave modport is the view of the requesters + peripheral.
// Revision    : 1.0 - initial release
// ============================================================================
interface mmio_bus_arbiter_if;

  // Requester 0 (core memory stage)
  logic        m0_req;
  logic        m0_wr;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic        m0_gnt;
  logic        m0_done;
  logic        m0_err;
  logic [31:0] m0_rdata;

  // Requester 1 (debug / DMA port)
  logic        m1_req;
  logic        m1_wr;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic        m1_gnt;
  logic        m1_done;
  logic        m1_err;
  logic [31:0] m1_rdata;

  // Shared MMIO bus
  logic [31:0] bus_addr;
  logic [31:0] bus_wr_data;
  logic        bus_cs;
  logic        bus_wr;
  logic        bus_rd;
  logic [31:0] bus_rd_data;
  logic        bus_ack;

  modport master (
    input  m0_req, m0_wr, m0_addr, m0_wdata,
    output m0_gnt, m0_done, m0_err, m0_rdata,
    input  m1_req, m1_wr, m1_addr, m1_wdata,
    output m1_gnt, m1_done, m1_err, m1_rdata,
    output bus_addr, bus_wr_data, bus_cs, bus_wr, bus_rd,
    input  bus_rd_data, bus_ack
  );

  modport slave (
    output m0_req, m0_wr, m0_addr, m0_wdata,
    input  m0_gnt, m0_done, m0_err, m0_rdata,
    output m1_req, m1_wr, m1_addr, m1_wdata,
    input  m1_gnt, m1_done, m1_err, m1_rdata,
    input  bus_addr, bus_wr_data, bus_cs, bus_wr, bus_rd,
    output bus_rd_data, bus_ack
  );

endinterface
`default_nettype wire

// File: rtl/mmio_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mmio_bus_arbiter
// Description : Round-robin arbiter sharing one MMIO bus between the core's
//               memory stage (m0) and the debug/DMA port (m1). Each granted
//               transaction is registered onto the bus, held until the
//               peripheral acks or a bounded timeout expires, then completed
//               with a one-cycle done pulse (plus read data / error flag) to
//               the owning requester.
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_bus_arbiter #(
  parameter int          TIMEOUT_CYCLES = 16,
  parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
  input  logic                clk,
  input  logic                reset,
  mmio_bus_arbiter_if.master  bus
);

  // Timer is one bit wider than needed to count to TIMEOUT_CYCLES-1 so that
  // the increment on the final ACTIVE cycle can never wrap.
  localparam int                     c_TIMER_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [c_TIMER_W-1:0]   c_TIMER_LAST = c_TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [c_TIMER_W-1:0]   c_TIMER_ONE  = c_TIMER_W'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t               r_state;
  logic                 r_prio;        // requester favoured on a tie
  logic                 r_owner;       // requester owning the current transaction
  logic                 r_wr;          // latched direction of current transaction
  logic [c_TIMER_W-1:0] r_timer;
  logic [31:0]          r_bus_addr;
  logic [31:0]          r_bus_wr_data;
  logic                 r_bus_cs;
  logic                 r_bus_wr;
  logic                 r_bus_rd;
  logic [1:0]           r_gnt;
  logic [1:0]           r_done;
  logic [1:0]           r_err;
  logic [31:0]          r_rdata0;
  logic [31:0]          r_rdata1;

  logic                 w_any_req;
  logic                 w_pick;
  logic                 w_sel_wr;
  logic [31:0]          w_sel_addr;
  logic [31:0]          w_sel_wdata;
  logic                 w_timeout;
  logic                 w_finish;
  logic                 w_cpl_err;
  logic [31:0]          w_cpl_data;

  // Request selection: a lone requester wins outright, a tie goes to r_prio.
  always_comb begin
    w_any_req   = bus.m0_req | bus.m1_req;
    w_pick      = bus.m1_req & (~bus.m0_req | r_prio);
    w_sel_wr    = w_pick ? bus.m1_wr    : bus.m0_wr;
    w_sel_addr  = w_pick ? bus.m1_addr  : bus.m0_addr;
    w_sel_wdata = w_pick ? bus.m1_wdata : bus.m0_wdata;
  end

  // Completion decode: an ack always beats a coincident timeout; writes
  // return zero data, timeouts return the error pattern.
  always_comb begin
    w_timeout  = (r_timer == c_TIMER_LAST);
    w_finish   = bus.bus_ack | w_timeout;
    w_cpl_err  = ~bus.bus_ack;
    w_cpl_data = ERR_DATA;
    if (bus.bus_ack) begin
      w_cpl_data = r_wr ? 32'd0 : bus.bus_rd_data;
    end
  end

  // Arbitration FSM with all bus and requester outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_prio        <= 1'b0;
      r_owner       <= 1'b0;
      r_wr          <= 1'b0;
      r_timer       <= '0;
      r_bus_addr    <= 32'd0;
      r_bus_wr_data <= 32'd0;
      r_bus_cs      <= 1'b0;
      r_bus_wr      <= 1'b0;
      r_bus_rd      <= 1'b0;
      r_gnt         <= 2'b00;
      r_done        <= 2'b00;
      r_err         <= 2'b00;
      r_rdata0      <= 32'd0;
      r_rdata1      <= 32'd0;
    end else begin
      // Completion outputs are single-cycle unless re-asserted below.
      r_done   <= 2'b00;
      r_err    <= 2'b00;
      r_rdata0 <= 32'd0;
      r_rdata1 <= 32'd0;

      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_state       <= S_ACTIVE;
            r_owner       <= w_pick;
            r_wr          <= w_sel_wr;
            r_bus_addr    <= w_sel_addr;
            r_bus_wr_data <= w_sel_wdata;
            r_timer       <= '0;
            r_bus_cs      <= 1'b1;
            r_bus_wr      <= w_sel_wr;
            r_bus_rd      <= ~w_sel_wr;
            r_gnt         <= w_pick ? 2'b10 : 2'b01;
          end
        end

        S_ACTIVE: begin
          r_timer <= r_timer + c_TIMER_ONE;
          if (w_finish) begin
            r_state  <= S_DONE;
            r_bus_cs <= 1'b0;
            r_bus_wr <= 1'b0;
            r_bus_rd <= 1'b0;
            r_done   <= r_owner ? 2'b10 : 2'b01;
            r_err    <= r_owner ? {w_cpl_err, 1'b0} : {1'b0, w_cpl_err};
            if (r_owner) begin
              r_rdata1 <= w_cpl_data;
            end else begin
              r_rdata0 <= w_cpl_data;
            end
          end
        end

        S_DONE: begin
          // Hand the tie-break to the requester that did not just finish.
          r_state <= S_IDLE;
          r_prio  <= ~r_owner;
          r_gnt   <= 2'b00;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.bus_addr    = r_bus_addr;
  assign bus.bus_wr_data = r_bus_wr_data;
  assign bus.bus_cs      = r_bus_cs;
  assign bus.bus_wr      = r_bus_wr;
  assign bus.bus_rd      = r_bus_rd;

  assign bus.m0_gnt   = r_gnt[0];
  assign bus.m0_done  = r_done[0];
  assign bus.m0_err   = r_err[0];
  assign bus.m0_rdata = r_rdata0;

  assign bus.m1_gnt   = r_gnt[1];
  assign bus.m1_done  = r_done[1];
  assign bus.m1_err   = r_err[1];
  assign bus.m1_rdata = r_rdata1;

endmodule
`default_nettype wire
